mux_rr_scanner: RTL
===================

# mux_rr_scanner

Round-robin scanner that drives the select input of the 8:1 4-bit channel mux (`eightbyonemux`) and registers the selected data. It sits directly upstream of the mux on `sel` and directly downstream of it on `yout`. It picks the next requesting channel fairly, allows one settle cycle for the combinational mux, captures the mux output with its channel index, and presents the result on a valid/ready handshake.

## Interface
Parameters:
- `NCH`, 8: number of channels. Fixed at 8; other values are unsupported.
- `SEL_W`, 3: select width, equal to log2(`NCH`).
- `DATA_W`, 4: data width, matching the mux data width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req`  in  8  level request per channel; bit i means channel i has data at mux input i.
- `sel`  out  3  registered select to mux `sel`.
- `mux_y`  in  4  mux `yout`.
- `out_valid`  out  1  `out_data` and `out_ch` are valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  4  captured channel data.
- `out_ch`  out  3  channel index of `out_data`.
- `grant`  out  8  one-hot, one-cycle pulse on the channel consumed at handshake.

## Operation
- States: IDLE, SETTLE, VALID.
- `ptr` (3 bits) holds the last granted channel. Pick = first set bit of the masked `req`, searching `ptr`+1, `ptr`+2, … and wrapping 7→0.
- IDLE:
  - If masked `req` is nonzero: `sel` <= pick, go to SETTLE.
  - Otherwise stay in IDLE with `sel` unchanged.
- SETTLE:
  - `out_data` <= `mux_y`, `out_ch` <= `sel`, go to VALID.
  - `req` is not sampled in this state.
- VALID:
  - `out_valid`=1. `out_data`, `out_ch` and `sel` are held stable until handshake.
  - Handshake (`out_valid` & `out_ready`): `grant[out_ch]` pulses that cycle, `ptr` <= `out_ch`.
  - In the same cycle, the pick runs with mask = `req` & ~(1<<`out_ch`). If nonzero: `sel` <= pick, go to SETTLE. Otherwise go to IDLE.
- Same channel back-to-back: the granted channel is masked on the handshake cycle, so the same channel is re-granted only via IDLE. That path costs one extra cycle, and the requester must deassert `req` within one cycle of `grant` if it has no new data.
- Requests dropped during SETTLE/VALID do not cancel the in-flight capture.
- `out_ready` outside VALID is ignored.
- `grant` is 0 except on handshake cycles.

## Timing
- Reset values: `sel`=0, `ptr`=7 (so the first search starts at channel 0), `out_valid`=0, `out_data`=0, `out_ch`=0, `grant`=0, state=IDLE.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). An in-flight capture is discarded and no `grant` is issued.
- Latency: `req` sampled in IDLE at edge N → `sel` valid after edge N → capture at edge N+1 → `out_valid` high after edge N+1. That is 2 cycles.
- Sustained throughput with `out_ready`=1 and ≥2 requesters: one result every 2 cycles (VALID, SETTLE alternating).
- `sel` changes only on the IDLE→SETTLE and VALID→SETTLE edges. The mux always has one full cycle to settle before capture.
- `out_ready` held low: remains in VALID indefinitely with all outputs stable.

## Structure
- Shared package `mux_pkg`:
  - constants `NCH`, `SEL_W`, `DATA_W`
  - state enum `scan_state_t` {IDLE, SETTLE, VALID}
- Sub-module `rr_pick8`: combinational.
  - Inputs: `req_masked` [7:0], `ptr` [2:0].
  - Outputs: `pick` [2:0], `any`.
  - Implemented as a rotate, priority-encode, and un-rotate.
  - Instantiated once. FSM and registers live in `mux_rr_scanner`.

## Test plan
- Reset, then `req`=8'h01, `mux_y`=4'hA when `sel`=0, `out_ready`=1 → `sel`=0, `out_valid` 2 cycles after `req`, `out_data`=4'hA, `out_ch`=0, `grant`=8'h01 for one cycle.
- `req`=8'hFF held, `out_ready`=1 → `out_ch` sequence 0,1,2,…,7,0, one result every 2 cycles, each `grant` one-hot matching `out_ch`.
- `ptr`=6, `req`=8'h81 → next `out_ch`=7, then 0 (wrap-around).
- `out_ready`=0 for 5 cycles in VALID while `mux_y` and `req` toggle → `out_valid`, `out_data`, `out_ch` and `sel` stable, `grant`=0. On `out_ready`=1, exactly one `grant` pulse.
- Single requester `req`=8'h08 held constant → grants on channel 3 via IDLE every 3 cycles, never back-to-back from VALID.
- `rst_n` low during SETTLE → `out_valid`=0, `sel`=0, `grant`=0 immediately. After release, the first grant is to the lowest requesting channel.

Source files
------------

// File: rtl/mux_rr_scanner_pkg.sv
// Shared constants, scanner state encoding and a one-hot helper for the 8:1 mux scanner.
// Channel count and widths are fixed by the downstream eightbyonemux.
package mux_pkg;
  localparam int NCH    = 8;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    VALID
  } scan_state_t;

  function automatic logic [NCH-1:0] ch_onehot(input logic [SEL_W-1:0] ch);
    logic [NCH-1:0] oh;
    oh     = '0;
    oh[ch] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/mux_rr_scanner_if.sv
// Request, mux select/data and result handshake bundle between scanner and its neighbours.
// master = scanner side, slave = requesters / mux / downstream consumer.
interface mux_rr_scanner_if;
  import mux_pkg::*;

  logic [NCH-1:0]    req;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] mux_y;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  out_ch;
  logic [NCH-1:0]    grant;

  modport master (
    input  req, mux_y, out_ready,
    output sel, out_valid, out_data, out_ch, grant
  );

  modport slave (
    output req, mux_y, out_ready,
    input  sel, out_valid, out_data, out_ch, grant
  );
endinterface

// File: rtl/mux_rr_scanner_pick.sv
// Combinational round-robin pick: first set bit of req_masked searching from ptr+1 upward, wrapping.
// Zero latency; no handshake.
module rr_pick8
  import mux_pkg::*;
(
  input  logic [NCH-1:0]   req_masked,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] pick,
  output logic             any
);
  logic [SEL_W-1:0] start;
  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;
  logic [SEL_W-1:0] off;

  always_comb begin
    start = ptr + SEL_W'(1);
    // Rotate so the search origin lands on bit 0, then priority-encode the lowest set bit.
    dbl   = {req_masked, req_masked} >> start;
    rot   = dbl[NCH-1:0];
    off   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) off = i[SEL_W-1:0];
    end
    pick = start + off;
    any  = |req_masked;
  end
endmodule

// File: rtl/mux_rr_scanner.sv
// Round-robin scanner: drives mux sel, waits one settle cycle, captures mux_y, offers it on valid/ready.
// Latency 2 cycles from request to out_valid; out_ready low holds all outputs stable in VALID.
module mux_rr_scanner
  import mux_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  mux_rr_scanner_if.master bus
);
  scan_state_t       state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;

  logic [NCH-1:0]    req_masked;
  logic [SEL_W-1:0]  pick_ptr;
  logic [SEL_W-1:0]  pick;
  logic              any;
  logic              hs;

  assign hs = (state_q == VALID) && bus.out_ready;

  // On the handshake cycle the search restarts after the consumed channel, which is masked out.
  always_comb begin
    req_masked = bus.req;
    pick_ptr   = ptr_q;
    if (state_q == VALID) begin
      req_masked = bus.req & ~ch_onehot(out_ch_q);
      pick_ptr   = out_ch_q;
    end
  end

  rr_pick8 u_pick (
    .req_masked (req_masked),
    .ptr        (pick_ptr),
    .pick       (pick),
    .any        (any)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          sel_d   = pick;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        out_data_d  = bus.mux_y;
        out_ch_d    = sel_q;
        out_valid_d = 1'b1;
        state_d     = VALID;
      end
      VALID: begin
        if (hs) begin
          ptr_d       = out_ch_q;
          out_valid_d = 1'b0;
          if (any) begin
            sel_d   = pick;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      ptr_q       <= SEL_W'(NCH - 1);
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.grant     = hs ? ch_onehot(out_ch_q) : '0;
endmodule
